// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole game core:
// state encodings, LFSR constants and default parameters.
package mole_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_ARM   = 3'd2,
        ST_PLAY  = 3'd3,
        ST_OVER  = 3'd4
    } game_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting left
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int DEF_N_MOLES     = 5;
    localparam int DEF_TICK_DIV    = 50;
    localparam int DEF_GAME_TICKS  = 30;
    localparam int DEF_SPAWN_TICKS = 1;
    localparam int DEF_MOLE_LIFE   = 3;
    localparam int DEF_SCORE_W     = 8;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mole_slot.sv
// One mole hole: occupancy flag plus remaining-life counter.
// Clear beats strike, strike beats expiry, so a struck mole never escapes.
module mole_slot
    import mole_pkg::*;
#(
    parameter int MOLE_LIFE = DEF_MOLE_LIFE
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic raise,
    input  logic strike,
    input  logic tick,
    output logic up,
    output logic escape
);

    logic       up_q, up_d;
    logic [3:0] life_q, life_d;

    always_comb begin
        up_d   = up_q;
        life_d = life_q;
        escape = 1'b0;
        if (clear) begin
            up_d   = 1'b0;
            life_d = '0;
        end else if (strike && up_q) begin
            up_d   = 1'b0;
            life_d = '0;
        end else if (up_q && tick) begin
            life_d = life_q - 4'd1;
            if (life_q == 4'd1) begin
                up_d   = 1'b0;
                escape = 1'b1;
            end
        end else if (raise && !up_q) begin
            up_d   = 1'b1;
            life_d = 4'(MOLE_LIFE);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            up_q   <= 1'b0;
            life_q <= '0;
        end else begin
            up_q   <= up_d;
            life_q <= life_d;
        end
    end

    assign up = up_q;

endmodule

// File: rtl/mole_game_core.sv
// Whack-a-mole game core: state machine, tick divider, LFSR spawner,
// strike evaluation and saturating score/miss counters.
module mole_game_core
    import mole_pkg::*;
#(
    parameter int N_MOLES     = DEF_N_MOLES,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int GAME_TICKS  = DEF_GAME_TICKS,
    parameter int SPAWN_TICKS = DEF_SPAWN_TICKS,
    parameter int MOLE_LIFE   = DEF_MOLE_LIFE,
    parameter int SCORE_W     = DEF_SCORE_W,
    localparam int IDX_W      = $clog2(N_MOLES + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               hit_valid,
    input  logic [IDX_W-1:0]   hit_idx,
    output logic [2:0]         state,
    output logic [N_MOLES-1:0] moles_up,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] misses,
    output logic [5:0]         time_left,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               escape_pulse,
    output logic               game_over
);

    localparam int DIV_W = $clog2(TICK_DIV + 1);
    localparam int SPN_W = $clog2(SPAWN_TICKS + 1);

    game_state_e        state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [SPN_W-1:0]   spn_q, spn_d;
    logic [5:0]         time_q, time_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] miss_q, miss_d;
    logic               hit_pulse_q, miss_pulse_q;
    logic               escape_pulse_q, game_over_q;

    logic               in_play, tick, spawn, expire_now;
    logic               hit, miss, slot_clear;
    logic [IDX_W-1:0]   spawn_sel;
    logic [N_MOLES-1:0] up_w, esc_w, strike, raise;

    assign in_play    = state_q == ST_PLAY;
    assign tick       = in_play && div_q == DIV_W'(TICK_DIV - 1);
    assign spawn      = tick && spn_q == SPN_W'(SPAWN_TICKS - 1);
    assign expire_now = tick && time_q == 6'd1;
    assign slot_clear = !in_play || expire_now;
    assign spawn_sel  = IDX_W'(lfsr_q % 16'(N_MOLES));

    // A strike on a hole also blocks a spawn into that hole this cycle
    always_comb begin
        strike = '0;
        raise  = '0;
        for (int i = 0; i < N_MOLES; i++) begin
            strike[i] = in_play && hit_valid
                     && hit_idx == IDX_W'(i + 1);
            raise[i]  = spawn && spawn_sel == IDX_W'(i)
                     && !strike[i];
        end
    end

    assign hit  = |(strike & up_w);
    assign miss = in_play && hit_valid && !hit;

    for (genvar g = 0; g < N_MOLES; g++) begin : g_slot
        mole_slot #(
            .MOLE_LIFE(MOLE_LIFE)
        ) u_slot (
            .clock (clock),
            .reset (reset),
            .clear (slot_clear),
            .raise (raise[g]),
            .strike(strike[g]),
            .tick  (tick),
            .up    (up_w[g]),
            .escape(esc_w[g])
        );
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        spn_d   = spn_q;
        time_d  = time_q;
        score_d = score_q;
        miss_d  = miss_q;
        lfsr_d  = lfsr_next(lfsr_q);
        case (state_q)
            ST_IDLE:  state_d = ST_READY;
            ST_READY: if (start) state_d = ST_ARM;
            ST_ARM: begin
                state_d = ST_PLAY;
                div_d   = '0;
                spn_d   = '0;
                time_d  = 6'(GAME_TICKS);
                score_d = '0;
                miss_d  = '0;
            end
            ST_PLAY: begin
                div_d = tick ? '0 : div_q + DIV_W'(1);
                if (spawn)     spn_d = '0;
                else if (tick) spn_d = spn_q + SPN_W'(1);
                if (tick)       time_d  = time_q - 6'd1;
                if (expire_now) state_d = ST_OVER;
                if (hit && score_q != '1)
                    score_d = score_q + SCORE_W'(1);
                if (miss && miss_q != '1)
                    miss_d = miss_q + SCORE_W'(1);
            end
            ST_OVER:  if (start) state_d = ST_ARM;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            div_q          <= '0;
            spn_q          <= '0;
            time_q         <= '0;
            lfsr_q         <= LFSR_SEED;
            score_q        <= '0;
            miss_q         <= '0;
            hit_pulse_q    <= 1'b0;
            miss_pulse_q   <= 1'b0;
            escape_pulse_q <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            div_q          <= div_d;
            spn_q          <= spn_d;
            time_q         <= time_d;
            lfsr_q         <= lfsr_d;
            score_q        <= score_d;
            miss_q         <= miss_d;
            hit_pulse_q    <= hit;
            miss_pulse_q   <= miss;
            escape_pulse_q <= |esc_w;
            game_over_q    <= state_d == ST_OVER;
        end
    end

    assign state        = state_q;
    assign moles_up     = up_w;
    assign score        = score_q;
    assign misses       = miss_q;
    assign time_left    = time_q;
    assign hit_pulse    = hit_pulse_q;
    assign miss_pulse   = miss_pulse_q;
    assign escape_pulse = escape_pulse_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_mole_game_core.sv
// Self-checking bench for mole_game_core against a behavioural
// game model (per-hole life counts, plain integer counters).
module tb_mole_game_core;

    localparam int N     = 5;
    localparam int TD    = 4;
    localparam int GT    = 8;
    localparam int SP    = 1;
    localparam int ML    = 1;
    localparam int SW    = 2;
    localparam int IDX_W = $clog2(N + 1);
    localparam int SMAX  = (1 << SW) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             hit_valid;
    logic [IDX_W-1:0] hit_idx;
    logic [2:0]       state;
    logic [N-1:0]     moles_up;
    logic [SW-1:0]    score;
    logic [SW-1:0]    misses;
    logic [5:0]       time_left;
    logic             hit_pulse, miss_pulse, escape_pulse, game_over;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model
    int m_state, m_div, m_spc, m_tl, m_lfsr, m_score, m_miss;
    int m_life[N];
    bit m_hitp, m_missp, m_escp, m_over;

    mole_game_core #(
        .N_MOLES(N), .TICK_DIV(TD), .GAME_TICKS(GT),
        .SPAWN_TICKS(SP), .MOLE_LIFE(ML), .SCORE_W(SW)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .hit_valid(hit_valid), .hit_idx(hit_idx),
        .state(state), .moles_up(moles_up), .score(score),
        .misses(misses), .time_left(time_left),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .escape_pulse(escape_pulse), .game_over(game_over)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, got no finish want finish");
        $fatal(1);
    end

    function automatic void model_reset();
        m_state = 0; m_div = 0; m_spc = 0; m_tl = 0;
        m_lfsr = 'hACE1; m_score = 0; m_miss = 0;
        m_hitp = 0; m_missp = 0; m_escp = 0; m_over = 0;
        for (int i = 0; i < N; i++) m_life[i] = 0;
    endfunction

    function automatic logic [N-1:0] exp_up();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = m_life[i] > 0;
        return v;
    endfunction

    function automatic int pick_up(input int prefer);
        if (prefer >= 1 && prefer <= N && m_life[prefer-1] > 0)
            return prefer;
        for (int i = 0; i < N; i++) if (m_life[i] > 0) return i + 1;
        return 0;
    endfunction

    function automatic void model_step(input bit st, input bit hv, input int hi);
        int  ns, sel, fb;
        bit  tick, spawn;
        int  old_life[N];
        m_hitp = 0; m_missp = 0; m_escp = 0;
        ns = m_state;
        case (m_state)
            0: ns = 1;
            1: if (st) ns = 2;
            2: begin
                ns = 3; m_score = 0; m_miss = 0;
                m_div = 0; m_spc = 0; m_tl = GT;
                for (int i = 0; i < N; i++) m_life[i] = 0;
            end
            3: begin
                old_life = m_life;
                tick  = (m_div == TD - 1);
                m_div = tick ? 0 : m_div + 1;
                spawn = 0;
                if (tick) begin
                    if (m_spc == SP - 1) begin spawn = 1; m_spc = 0; end
                    else m_spc++;
                end
                sel = m_lfsr % N;
                if (hv) begin
                    if (hi >= 1 && hi <= N && m_life[hi-1] > 0) begin
                        m_hitp = 1; m_life[hi-1] = 0;
                        if (m_score < SMAX) m_score++;
                    end else begin
                        m_missp = 1;
                        if (m_miss < SMAX) m_miss++;
                    end
                end
                if (tick)
                    for (int i = 0; i < N; i++)
                        if (m_life[i] > 0) begin
                            m_life[i]--;
                            if (m_life[i] == 0) m_escp = 1;
                        end
                if (spawn && old_life[sel] == 0 && !(hv && hi == sel + 1))
                    m_life[sel] = ML;
                if (tick) begin
                    if (m_tl == 1) begin
                        ns = 4; m_escp = 0;
                        for (int i = 0; i < N; i++) m_life[i] = 0;
                    end
                    m_tl--;
                end
            end
            4: if (st) ns = 2;
            default: ns = 0;
        endcase
        m_state = ns;
        m_over  = (ns == 4);
        fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 'hFFFF;
    endfunction

    task automatic step(input bit st, input bit hv, input int hi);
        start = st; hit_valid = hv; hit_idx = IDX_W'(hi);
        @(posedge clock);
        model_step(st, hv, hi);
        #1;
    endtask

    task automatic new_game();
        int g;
        g = 0;
        while (m_state == 3 && g < 500) begin step(0, 0, 0); g++; end
        while (m_state != 3 && g < 500) begin
            step(m_state == 1 || m_state == 4, 0, 0); g++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; hit_valid = 0; hit_idx = '0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state);
        else n_pass++;
        n_checks++;
        if ({moles_up, score, misses, time_left, hit_pulse, miss_pulse,
             escape_pulse, game_over} !== '0)
            $display("FAIL reset_outputs: got up=%b sc=%0d ms=%0d tl=%0d p=%b%b%b go=%b want all 0",
                     moles_up, score, misses, time_left, hit_pulse, miss_pulse, escape_pulse, game_over);
        else n_pass++;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_start_seq();
        int seq[3];
        seq = '{1, 2, 3};
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0);
            n_checks++;
            if (state !== 3'(seq[k]))
                $display("FAIL start_seq%0d: got %0d want %0d", k, state, seq[k]);
            else n_pass++;
        end
        n_checks++;
        if (time_left !== 6'(GT)) $display("FAIL first_play_time: got %0d want %0d", time_left, GT);
        else n_pass++;
        n_checks++;
        if (score !== '0) $display("FAIL first_play_score: got %0d want 0", score);
        else n_pass++;
    endtask

    task automatic test_expiry();
        int cnt;
        cnt = 0;
        while (state !== 3'd4 && cnt < 400) begin step(0, 0, 0); cnt++; end
        n_checks++;
        if (cnt != TD * GT) $display("FAIL expiry_clocks: got %0d want %0d", cnt, TD * GT);
        else n_pass++;
        n_checks++;
        if (game_over !== 1'b1) $display("FAIL expiry_game_over: got %b want 1", game_over);
        else n_pass++;
        n_checks++;
        if (moles_up !== '0) $display("FAIL expiry_moles: got %b want 0", moles_up);
        else n_pass++;
        n_checks++;
        if (time_left !== 6'd0) $display("FAIL expiry_time: got %0d want 0", time_left);
        else n_pass++;
    endtask

    task automatic test_hit();
        int g, h, want;
        new_game();
        g = 0; h = 0;
        while (g < 200) begin
            h = pick_up(2);
            if (h != 0) break;
            if (m_state == 4) new_game(); else step(0, 0, 0);
            g++;
        end
        n_checks++;
        if (h == 0) begin
            $display("FAIL hit_wait: got no mole want a mole within 200 cycles");
        end else begin
            n_pass++;
            want = (m_score < SMAX) ? m_score + 1 : SMAX;
            step(0, 1, h);
            n_checks++;
            if (hit_pulse !== 1'b1) $display("FAIL hit_pulse: got %b want 1", hit_pulse);
            else n_pass++;
            n_checks++;
            if (score !== SW'(want)) $display("FAIL hit_score: got %0d want %0d", score, want);
            else n_pass++;
            n_checks++;
            if (moles_up[h-1] !== 1'b0)
                $display("FAIL hit_lowered: got %b want 0 (hole %0d)", moles_up[h-1], h);
            else n_pass++;
        end
    endtask

    task automatic test_miss();
        int held;
        int holes[4];
        int want_m[4];
        holes  = '{4, 7, 0, 5};
        want_m = '{1, 2, 3, 3};
        new_game();
        while (m_state != 4) step(0, 0, 0);
        held = m_miss;
        step(0, 1, 1);
        n_checks++;
        if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0)
            $display("FAIL ignore_pulses: got h=%b m=%b want 0 0", hit_pulse, miss_pulse);
        else n_pass++;
        n_checks++;
        if (misses !== SW'(held)) $display("FAIL ignore_misses: got %0d want %0d", misses, held);
        else n_pass++;
        new_game();
        for (int k = 0; k < 4; k++) begin
            step(0, 1, holes[k]);
            n_checks++;
            if (miss_pulse !== 1'b1 || misses !== SW'(want_m[k]) || score !== '0)
                $display("FAIL miss_idx%0d: got mp=%b ms=%0d sc=%0d want mp=1 ms=%0d sc=0",
                         holes[k], miss_pulse, misses, score, want_m[k]);
            else n_pass++;
        end
    endtask

    task automatic test_escape();
        int g, h, cnt;
        new_game();
        g = 0;
        while (pick_up(0) == 0 && g < 40) begin step(0, 0, 0); g++; end
        h = pick_up(0);
        cnt = 0;
        while (escape_pulse !== 1'b1 && cnt < 100) begin step(0, 0, 0); cnt++; end
        n_checks++;
        if (h == 0 || cnt != TD * ML)
            $display("FAIL escape_delay: got %0d want %0d (hole %0d)", cnt, TD * ML, h);
        else n_pass++;
        n_checks++;
        if (h == 0 || moles_up[h-1] !== 1'b0)
            $display("FAIL escape_lowered: got %b want 0", moles_up);
        else n_pass++;
    endtask

    task automatic test_strike_on_expiry();
        int g, h;
        new_game();
        g = 0;
        while (pick_up(0) == 0 && g < 40) begin step(0, 0, 0); g++; end
        h = pick_up(0);
        g = 0;
        while (m_div != TD - 1 && g < 20) begin step(0, 0, 0); g++; end
        step(0, 1, h);
        n_checks++;
        if (h == 0 || hit_pulse !== 1'b1)
            $display("FAIL expiry_strike_hit: got %b want 1 (hole %0d)", hit_pulse, h);
        else n_pass++;
        n_checks++;
        if (escape_pulse !== 1'b0)
            $display("FAIL expiry_strike_escape: got %b want 0", escape_pulse);
        else n_pass++;
    endtask

    task automatic test_saturate();
        int g, h, hits, want;
        new_game();
        g = 0; hits = 0;
        while (m_state != 4 && g < 200) begin
            h = pick_up(0);
            if (h != 0) begin step(0, 1, h); hits++; end
            else step(0, 0, 0);
            g++;
        end
        want = (hits > SMAX) ? SMAX : hits;
        n_checks++;
        if (hits < 4 || score !== SW'(want))
            $display("FAIL saturate_score: got %0d want %0d (hits %0d)", score, want, hits);
        else n_pass++;
        n_checks++;
        if (game_over !== 1'b1) $display("FAIL saturate_over: got %b want 1", game_over);
        else n_pass++;
    endtask

    task automatic test_reset_midplay();
        new_game();
        repeat (6) step(0, 1, $urandom_range(0, 7));
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({state, moles_up, score, misses, time_left, hit_pulse,
             miss_pulse, escape_pulse, game_over} !== '0)
            $display("FAIL midplay_reset: got st=%0d up=%b sc=%0d ms=%0d tl=%0d go=%b want all 0",
                     state, moles_up, score, misses, time_left, game_over);
        else n_pass++;
        @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bit st, hv;
            int hi;
            st = ($urandom_range(0, 3) == 0);
            hv = ($urandom_range(0, 1) == 1);
            hi = pick_up($urandom_range(1, N));
            if (hi == 0 || $urandom_range(0, 3) == 0) hi = $urandom_range(0, 7);
            step(st, hv, hi);
            n_checks++;
            if (state !== 3'(m_state) || moles_up !== exp_up()
                || score !== SW'(m_score) || misses !== SW'(m_miss)
                || time_left !== 6'(m_tl) || hit_pulse !== m_hitp
                || miss_pulse !== m_missp || escape_pulse !== m_escp
                || game_over !== m_over)
                $display("FAIL random_c%0d: got st=%0d up=%b sc=%0d ms=%0d tl=%0d p=%b%b%b go=%b want st=%0d up=%b sc=%0d ms=%0d tl=%0d p=%b%b%b go=%b",
                         c, state, moles_up, score, misses, time_left,
                         hit_pulse, miss_pulse, escape_pulse, game_over,
                         m_state, exp_up(), m_score, m_miss, m_tl,
                         m_hitp, m_missp, m_escp, m_over);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_start_seq();
        test_expiry();
        test_hit();
        test_miss();
        test_escape();
        test_strike_on_expiry();
        test_saturate();
        test_reset_midplay();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
